// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared access types, request encodings and controller states
package mem_ctrl_pkg;

    typedef logic [1:0]  ls_type_t;
    typedef logic [31:0] data_t;
    typedef logic [31:0] addr_t;

    localparam ls_type_t BYTE_TYPE = 2'b00;
    localparam ls_type_t HALF_TYPE = 2'b01;
    localparam ls_type_t WORD_TYPE = 2'b10;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_STORE = 2'd3
    } status_t;

    // Index of the final byte of an access; the unused encoding behaves as a word.
    function automatic logic [1:0] last_idx(input ls_type_t t);
        case (t)
            BYTE_TYPE: last_idx = 2'd0;
            HALF_TYPE: last_idx = 2'd1;
            default:   last_idx = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM/IO controller arbitrating LSB and icache requests
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clr,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        icache_to_mc_enable,
    input  logic [31:0] icache_to_mc_addr,
    output logic        mc_to_icache_done,
    output logic [31:0] mc_to_icache_inst,
    input  logic        lsb_to_mc_enable,
    input  logic        lsb_to_mc_wr,
    input  logic [1:0]  lsb_to_mc_ls_type,
    input  logic [31:0] lsb_to_mc_addr,
    input  logic [31:0] lsb_to_mc_st_val,
    output logic        mc_to_lsb_ld_done,
    output logic        mc_to_lsb_st_done,
    output logic [31:0] mc_to_lsb_ld_val
);

    status_t    state_q;
    logic [1:0] cnt_q;
    logic [1:0] last_q;
    addr_t      mem_a_q;
    logic [7:0] mem_dout_q;
    logic       mem_wr_q;
    logic       ic_done_q;
    logic       ld_done_q;
    logic       st_done_q;
    data_t      inst_q;
    data_t      ld_val_q;
    data_t      data_q;
    data_t      st_q;

    logic  any_done;
    logic  io_blocked;
    logic  lsb_go;
    logic  ic_go;
    data_t data_d;

    assign any_done   = ic_done_q | ld_done_q | st_done_q;
    assign io_blocked = (lsb_to_mc_wr == MEM_WRITE) && (lsb_to_mc_addr[17:16] == IO_ADDR_HI)
                        && io_buffer_full;
    // A flushed load is dropped, but a committed store may still start under clr.
    assign lsb_go     = lsb_to_mc_enable && !io_blocked && !(clr && lsb_to_mc_wr == MEM_READ);
    assign ic_go      = icache_to_mc_enable && !lsb_to_mc_enable && !clr;

    always_comb begin
        data_d = data_q;
        case (cnt_q)
            2'd0:    data_d[7:0]   = mem_din;
            2'd1:    data_d[15:8]  = mem_din;
            2'd2:    data_d[23:16] = mem_din;
            default: data_d[31:24] = mem_din;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            last_q     <= 2'd0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            ic_done_q  <= 1'b0;
            ld_done_q  <= 1'b0;
            st_done_q  <= 1'b0;
            inst_q     <= '0;
            ld_val_q   <= '0;
            data_q     <= '0;
            st_q       <= '0;
        end else if (rdy) begin
            ic_done_q <= 1'b0;
            ld_done_q <= 1'b0;
            st_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!any_done && lsb_go) begin
                        mem_a_q <= lsb_to_mc_addr;
                        cnt_q   <= 2'd0;
                        last_q  <= last_idx(lsb_to_mc_ls_type);
                        data_q  <= '0;
                        if (lsb_to_mc_wr == MEM_WRITE) begin
                            state_q    <= ST_STORE;
                            mem_wr_q   <= 1'b1;
                            mem_dout_q <= lsb_to_mc_st_val[7:0];
                            st_q       <= {8'h00, lsb_to_mc_st_val[31:8]};
                        end else begin
                            state_q  <= ST_LOAD;
                            mem_wr_q <= 1'b0;
                        end
                    end else if (!any_done && ic_go) begin
                        state_q  <= ST_FETCH;
                        mem_a_q  <= icache_to_mc_addr;
                        mem_wr_q <= 1'b0;
                        cnt_q    <= 2'd0;
                        last_q   <= 2'd3;
                        data_q   <= '0;
                    end
                end
                ST_FETCH, ST_LOAD: begin
                    if (clr) begin
                        state_q  <= ST_IDLE;
                        mem_wr_q <= 1'b0;
                        mem_a_q  <= '0;
                        cnt_q    <= 2'd0;
                    end else if (cnt_q == last_q) begin
                        state_q <= ST_IDLE;
                        mem_a_q <= '0;
                        cnt_q   <= 2'd0;
                        if (state_q == ST_FETCH) begin
                            inst_q    <= data_d;
                            ic_done_q <= 1'b1;
                        end else begin
                            ld_val_q  <= data_d;
                            ld_done_q <= 1'b1;
                        end
                    end else begin
                        data_q  <= data_d;
                        cnt_q   <= cnt_q + 2'd1;
                        mem_a_q <= mem_a_q + 32'd1;
                    end
                end
                ST_STORE: begin
                    if (cnt_q == last_q) begin
                        state_q   <= ST_IDLE;
                        mem_wr_q  <= 1'b0;
                        mem_a_q   <= '0;
                        cnt_q     <= 2'd0;
                        st_done_q <= 1'b1;
                    end else begin
                        mem_a_q    <= mem_a_q + 32'd1;
                        mem_dout_q <= st_q[7:0];
                        st_q       <= {8'h00, st_q[31:8]};
                        cnt_q      <= cnt_q + 2'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_a             = mem_a_q;
    assign mem_dout          = mem_dout_q;
    assign mem_wr            = mem_wr_q;
    assign mc_to_icache_done = ic_done_q;
    assign mc_to_icache_inst = inst_q;
    assign mc_to_lsb_ld_done = ld_done_q;
    assign mc_to_lsb_st_done = st_done_q;
    assign mc_to_lsb_ld_val  = ld_val_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        clr = 1'b0;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic        ic_en = 1'b0;
    logic [31:0] ic_addr = '0;
    logic        ic_done;
    logic [31:0] ic_inst;
    logic        lsb_en = 1'b0;
    logic        lsb_wr = 1'b0;
    logic [1:0]  lsb_type = 2'b00;
    logic [31:0] lsb_addr = '0;
    logic [31:0] lsb_val = '0;
    logic        ld_done;
    logic        st_done;
    logic [31:0] ld_val;

    logic [7:0] ram  [0:65535];
    logic [7:0] wlog [0:65535];
    int wr_cnt = 0;
    int checks = 0;
    int failures = 0;
    int wr_base;

    always #5 clk = ~clk;

    mem_ctrl #(.IO_ADDR_HI(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .icache_to_mc_enable(ic_en), .icache_to_mc_addr(ic_addr),
        .mc_to_icache_done(ic_done), .mc_to_icache_inst(ic_inst),
        .lsb_to_mc_enable(lsb_en), .lsb_to_mc_wr(lsb_wr), .lsb_to_mc_ls_type(lsb_type),
        .lsb_to_mc_addr(lsb_addr), .lsb_to_mc_st_val(lsb_val),
        .mc_to_lsb_ld_done(ld_done), .mc_to_lsb_st_done(st_done), .mc_to_lsb_ld_val(ld_val)
    );

    assign mem_din = ram[mem_a[15:0]];

    always @(posedge clk) begin
        if (mem_wr && rdy && rst) begin
            wlog[mem_a[15:0]] <= mem_dout;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch_check(input logic [31:0] addr, input logic [31:0] exp_inst);
        ic_en = 1'b1;
        ic_addr = addr;
        tick();
        check("fetch_a0", mem_a, addr);
        check("fetch_rd", {31'b0, mem_wr}, 32'd0);
        for (int k = 1; k < 4; k++) begin
            tick();
            check("fetch_ak", mem_a, addr + k);
            check("fetch_nodone", {31'b0, ic_done}, 32'd0);
        end
        tick();
        check("fetch_done", {31'b0, ic_done}, 32'd1);
        check("fetch_inst", ic_inst, exp_inst);
        check("fetch_a_clr", mem_a, 32'd0);
        ic_en = 1'b0;
        tick();
        check("fetch_pulse", {31'b0, ic_done}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05;
        ram[16'h2000] = 8'hEF; ram[16'h2001] = 8'hBE;
        ram[16'h2002] = 8'hAD; ram[16'h2003] = 8'hDE;

        @(negedge clk);
        check("rst_a", mem_a, 32'd0);
        check("rst_dout", {24'b0, mem_dout}, 32'd0);
        check("rst_dones", {29'b0, mem_wr, ic_done, ld_done | st_done}, 32'd0);
        check("rst_vals", ic_inst | ld_val, 32'd0);
        rst = 1'b1;
        tick();

        fetch_check(32'h1000, 32'h00000513);

        // LSB word load colliding with a fetch
        lsb_en = 1'b1; lsb_wr = MEM_READ; lsb_type = WORD_TYPE; lsb_addr = 32'h2000;
        ic_en = 1'b1; ic_addr = 32'h1000;
        tick();
        check("lw_a0", mem_a, 32'h2000);
        repeat (3) tick();
        check("lw_a3", mem_a, 32'h2003);
        tick();
        check("lw_done", {31'b0, ld_done}, 32'd1);
        check("lw_val", ld_val, 32'hDEADBEEF);
        check("lw_ic_wait", {31'b0, ic_done}, 32'd0);
        lsb_en = 1'b0;
        tick();
        check("gap_a", mem_a, 32'd0);
        tick();
        check("ic_after_a0", mem_a, 32'h1000);
        repeat (3) tick();
        tick();
        check("ic_after_done", {31'b0, ic_done}, 32'd1);
        check("ic_after_inst", ic_inst, 32'h00000513);
        ic_en = 1'b0;
        tick();

        // misaligned halfword store
        wr_base = wr_cnt;
        lsb_en = 1'b1; lsb_wr = MEM_WRITE; lsb_type = HALF_TYPE;
        lsb_addr = 32'h3001; lsb_val = 32'h1234ABCD;
        tick();
        check("sh_b0", {mem_wr, 15'b0, mem_a[15:0]}, 32'h80003001);
        check("sh_d0", {24'b0, mem_dout}, 32'h000000CD);
        tick();
        check("sh_b1", {mem_wr, 15'b0, mem_a[15:0]}, 32'h80003002);
        check("sh_d1", {24'b0, mem_dout}, 32'h000000AB);
        tick();
        check("sh_done", {30'b0, mem_wr, st_done}, 32'd1);
        check("sh_wrcnt", wr_cnt - wr_base, 32'd2);
        check("sh_mem", {16'b0, wlog[16'h3002], wlog[16'h3001]}, 32'h0000ABCD);
        lsb_en = 1'b0;
        tick();

        // flush a byte load on its final edge
        lsb_en = 1'b1; lsb_wr = MEM_READ; lsb_type = BYTE_TYPE; lsb_addr = 32'h1000;
        tick();
        check("lb_a0", mem_a, 32'h1000);
        clr = 1'b1; lsb_en = 1'b0;
        tick();
        check("lb_clr", {30'b0, mem_wr, ld_done}, 32'd0);
        check("lb_clr_a", mem_a, 32'd0);
        ic_en = 1'b1; ic_addr = 32'h1000;
        tick();
        check("clr_blocks_ic", mem_a, 32'd0);
        ic_en = 1'b0;

        // store accepted and continued under clr
        lsb_en = 1'b1; lsb_wr = MEM_WRITE; lsb_type = WORD_TYPE;
        lsb_addr = 32'h3010; lsb_val = 32'h11223344;
        tick();
        check("sw_b0", {mem_wr, 15'b0, mem_a[15:0]}, 32'h80003010);
        tick();
        check("sw_b1", {mem_wr, 15'b0, mem_a[15:0]}, 32'h80003011);
        clr = 1'b0;
        repeat (2) tick();
        check("sw_b3", {mem_wr, 15'b0, mem_a[15:0]}, 32'h80003013);
        tick();
        check("sw_done", {30'b0, mem_wr, st_done}, 32'd1);
        check("sw_mem", {wlog[16'h3013], wlog[16'h3012], wlog[16'h3011], wlog[16'h3010]}, 32'h11223344);
        lsb_en = 1'b0;
        tick();

        // IO byte store gated by io_buffer_full
        lsb_en = 1'b1; lsb_wr = MEM_WRITE; lsb_type = BYTE_TYPE;
        lsb_addr = 32'h00030000; lsb_val = 32'h0000005A;
        io_buffer_full = 1'b1; ic_en = 1'b1; ic_addr = 32'h1000;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("io_gate", {mem_wr, mem_a[30:0]}, 32'd0);
        end
        io_buffer_full = 1'b0;
        tick();
        check("io_a", {mem_wr, mem_a[30:0]}, 32'h80030000);
        check("io_d", {24'b0, mem_dout}, 32'h0000005A);
        io_buffer_full = 1'b1;
        tick();
        check("io_done", {30'b0, mem_wr, st_done}, 32'd1);
        lsb_en = 1'b0; ic_en = 1'b0; io_buffer_full = 1'b0;
        tick();

        // rdy stall in the middle of a word load
        lsb_en = 1'b1; lsb_wr = MEM_READ; lsb_type = WORD_TYPE; lsb_addr = 32'h2000;
        repeat (2) tick();
        check("stall_a1", mem_a, 32'h2001);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_hold", {ld_done, mem_a[30:0]}, 32'h00002001);
        end
        rdy = 1'b1;
        tick();
        check("stall_a2", mem_a, 32'h2002);
        tick();
        tick();
        check("stall_done", {31'b0, ld_done}, 32'd1);
        check("stall_val", ld_val, 32'hDEADBEEF);
        lsb_en = 1'b0;
        tick();

        // asynchronous reset in the middle of a store
        lsb_en = 1'b1; lsb_wr = MEM_WRITE; lsb_type = WORD_TYPE;
        lsb_addr = 32'h3020; lsb_val = 32'hCAFEF00D;
        repeat (2) tick();
        check("pre_rst_wr", {31'b0, mem_wr}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_wr", {29'b0, mem_wr, st_done, ld_done}, 32'd0);
        check("arst_a", mem_a, 32'd0);
        @(negedge clk);
        lsb_en = 1'b0;
        rst = 1'b1;
        tick();
        fetch_check(32'h1000, 32'h00000513);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller directly downstream of the load/store buffer; it also serves instruction-fetch requests.
- Arbitrates between the LSB and the icache, serialises word, half and byte accesses onto the 8-bit RAM/IO port, and returns completion pulses.
- Honours pipeline flush (clr), the global rdy stall, and IO back-pressure (io_buffer_full).

Parameters:
- IO_ADDR_HI, 2'b11: value of addr[17:16] that marks the IO region.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- rdy  in  1  global ready; low freezes the block
- clr  in  1  flush from ROB mispredict
- mem_din  in  8  RAM/IO read byte, valid the cycle after mem_a was presented
- mem_dout  out  8  write byte
- mem_a  out  32  byte address
- mem_wr  out  1  1 = write (MEM_WRITE), 0 = read
- io_buffer_full  in  1  IO write buffer full
- icache_to_mc_enable  in  1  fetch request, level, held until done
- icache_to_mc_addr  in  32  fetch address, 4 bytes
- mc_to_icache_done  out  1  one-cycle pulse
- mc_to_icache_inst  out  32  fetched word, valid with done
- lsb_to_mc_enable  in  1  LSB request, level, held until done
- lsb_to_mc_wr  in  1  MEM_READ/MEM_WRITE
- lsb_to_mc_ls_type  in  2  BYTE_TYPE/HALF_TYPE/WORD_TYPE (1/2/4 bytes)
- lsb_to_mc_addr  in  32  access address
- lsb_to_mc_st_val  in  32  store data; low bytes used
- mc_to_lsb_ld_done  out  1  one-cycle pulse
- mc_to_lsb_st_done  out  1  one-cycle pulse
- mc_to_lsb_ld_val  out  32  raw little-endian bytes, zero-filled above length; LSB does sign/zero extension

Behaviour:
- Reset (rst=0, async): state IDLE, byte counter 0. mem_a, mem_dout, mem_wr, both dones, mc_to_icache_inst and mc_to_lsb_ld_val all 0.
- States: IDLE, FETCH, LOAD, STORE.
- rdy=0: all registers hold, including outputs and counter. rst still acts.
- Dones are registered and high for exactly one cycle. The edge that raises done also returns the state to IDLE.
- A new request is accepted no earlier than the edge after done is high; a level request still high in the done cycle is not re-accepted.
- IDLE arbitration, fixed priority:
  - LSB request first.
  - Icache only when LSB enable = 0.
  - An LSB write with addr[17:16]==IO_ADDR_HI is not accepted while io_buffer_full=1, and icache is not served in its place that cycle.
- Request length n: BYTE=1, HALF=2, WORD=4. Fetch is always 4.
- Read (FETCH/LOAD), accepted at edge E0:
  - mem_a=addr, mem_wr=0 from E0.
  - At edge Ek (k=1..n-1) mem_a=addr+k, and byte k-1 is captured from mem_din into bits [8(k-1)+7:8(k-1)].
  - At edge En the last byte is captured, done=1, data output valid, state returns to IDLE, mem_a=0.
  - Latency: done visible n cycles after acceptance (word: 4).
- Store, accepted at edge E0:
  - At Ek (k=0..n-1): mem_a=addr+k, mem_dout=st_val[8k+7:8k], mem_wr=1.
  - At En: mem_wr=0, mem_a=0, st_done=1, state IDLE.
- Address arithmetic is 32-bit modulo. No alignment requirement; misaligned accesses are handled bytewise.
- clr=1 (with rdy=1):
  - FETCH or LOAD: abort to IDLE, mem_wr=0, no done pulse, counter 0, not even if the abort edge would have been En.
  - STORE: continues unaffected (committed) and completes with st_done.
  - IDLE: clr blocks icache acceptance that cycle; an LSB store may still be accepted.
- Simultaneous icache and LSB requests in IDLE: LSB wins. The icache request stays pending and is served after LSB done.
- IO store with io_buffer_full rising mid-store: the store runs to completion; the gate applies only at acceptance.
- After any IO store, at least one idle cycle is required before the next IO store is accepted (io_buffer_full reports one cycle late).

Decomposition:
- definition.v (shared):
  - LS_TYPE and BYTE/HALF/WORD_TYPE
  - MEM_READ/MEM_WRITE
  - DATA_TYPE, ADDR_TYPE
  - STATUS_TYPE plus the mem_ctrl state encodings
- Single module; no sub-module. Byte steering is a small case inside.

Test Plan:
- Reset: drive rst=0 mid-STORE -> mem_wr=0, all dones 0, state IDLE immediately (asynchronously); after release, a fetch at 0x0 completes normally.
- Fetch: icache addr 0x1000, RAM bytes 13,05,00,00 -> mem_a 0x1000..0x1003; icache_done pulse at acceptance+4 cycles with inst=0x00000513.
- LW vs fetch collision: both request in the same cycle, LSB LW 0x2000 = 0xDEADBEEF -> ld_done first with 0xDEADBEEF; fetch starts the cycle after and completes.
- SH 0x3001 val=0x1234ABCD -> writes CD@0x3001, AB@0x3002, mem_wr high exactly 2 cycles; st_done one cycle later.
- clr during LOAD (LB, cycle 1) -> no ld_done, mem_wr 0, IDLE. clr during SW -> all 4 bytes written, st_done asserted.
- IO SB to 0x30000 with io_buffer_full=1 for 3 cycles -> no mem_wr until the flag drops, then a 1-byte write and st_done; with rdy=0 mid-load, outputs and counter frozen and done delayed by the stall length.
